// File: rtl/backoff_pkg.sv
// rtl/backoff_pkg.sv - shared types, constants and sizing helper for the backoff engine
package backoff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_AIFS = 2'd1,
      ST_BACKOFF   = 2'd2,
      ST_DONE      = 2'd3
   } bo_state_e;

   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam int          CW_EXP_MAX_DEF = 10;

   // Bits needed to hold any value in 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR (right-shifting, tap mask on feedback)
module lfsr16
   import backoff_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter logic [15:0] TAPS = LFSR_TAPS
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? TAPS : 16'h0000);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/backoff_ctl.sv
// rtl/backoff_ctl.sv - per-queue channel-access backoff: random draw, AIFS wait, slot countdown
module backoff_ctl
   import backoff_pkg::*;
#(
   parameter int          SLOT_CYCLES = 900,
   parameter int          SIFS_CYCLES = 1600,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          CW_EXP_MAX  = CW_EXP_MAX_DEF
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start_req,
   input  logic [3:0] cw_exp,
   input  logic [3:0] aifsn,
   input  logic       ch_idle,
   input  logic       abort,
   output logic       backoff_done,
   output logic       busy,
   output logic [9:0] bo_remain,
   output logic [1:0] bo_state
);

   localparam int          CW      = cnt_width(SIFS_CYCLES + 15 * SLOT_CYCLES);
   localparam int          SW      = cnt_width(SLOT_CYCLES - 1);
   localparam logic [3:0]  CW_MAX4 = 4'(CW_EXP_MAX);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

   bo_state_e      state_q, state_d;
   logic [CW-1:0]  aifs_len_q, aifs_len_d;
   logic [CW-1:0]  aifs_cnt_q, aifs_cnt_d;
   logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
   logic [9:0]     remain_q, remain_d;
   logic           done_q, busy_q;

   logic [15:0]    lfsr_w;
   logic           unused_lfsr_hi;
   logic [3:0]     exp_clamped;
   logic [9:0]     draw_mask;
   logic [9:0]     draw;
   logic [CW-1:0]  aifs_calc;

   lfsr16 #(
      .SEED (LFSR_SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk     (clk),
      .rstn    (rstn),
      .state_o (lfsr_w)
   );

   assign unused_lfsr_hi = ^lfsr_w[15:10];

   always_comb begin
      exp_clamped = (cw_exp > CW_MAX4) ? CW_MAX4 : cw_exp;
      draw_mask   = 10'((11'd1 << exp_clamped) - 11'd1);
      draw        = lfsr_w[9:0] & draw_mask;
      aifs_calc   = CW'(SIFS_CYCLES) + CW'(aifsn) * CW'(SLOT_CYCLES);
   end

   always_comb begin
      state_d    = state_q;
      aifs_len_d = aifs_len_q;
      aifs_cnt_d = aifs_cnt_q;
      slot_cnt_d = slot_cnt_q;
      remain_d   = remain_q;

      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               remain_d   = draw;
               aifs_len_d = aifs_calc;
               aifs_cnt_d = '0;
               state_d    = ST_WAIT_AIFS;
            end
         end
         ST_WAIT_AIFS: begin
            // Any busy cycle restarts the whole AIFS interval.
            if (!ch_idle) begin
               aifs_cnt_d = '0;
            end else if (aifs_cnt_q == aifs_len_q - CW'(1)) begin
               aifs_cnt_d = '0;
               slot_cnt_d = '0;
               state_d    = (remain_q == 10'd0) ? ST_DONE : ST_BACKOFF;
            end else begin
               aifs_cnt_d = aifs_cnt_q + CW'(1);
            end
         end
         ST_BACKOFF: begin
            if (!ch_idle) begin
               slot_cnt_d = '0;
               aifs_cnt_d = '0;
               state_d    = ST_WAIT_AIFS;
            end else if (slot_cnt_q == SLOT_LAST) begin
               slot_cnt_d = '0;
               if (remain_q != 10'd0) begin
                  remain_d = remain_q - 10'd1;
               end
               if (remain_q <= 10'd1) begin
                  state_d = ST_DONE;
               end
            end else begin
               slot_cnt_d = slot_cnt_q + SW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over any pending transition, including the one into DONE.
      if (abort && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         aifs_cnt_d = '0;
         slot_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         aifs_len_q <= '0;
         aifs_cnt_q <= '0;
         slot_cnt_q <= '0;
         remain_q   <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         aifs_len_q <= aifs_len_d;
         aifs_cnt_q <= aifs_cnt_d;
         slot_cnt_q <= slot_cnt_d;
         remain_q   <= remain_d;
         done_q     <= (state_d == ST_DONE);
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign backoff_done = done_q;
   assign busy         = busy_q;
   assign bo_remain    = remain_q;
   assign bo_state     = state_q;

endmodule

// File: tb/tb_backoff_ctl.sv
// tb/tb_backoff_ctl.sv - directed self-checking bench for backoff_ctl (SLOT_CYCLES=4, SIFS_CYCLES=2)
module tb_backoff_ctl;

   localparam int SLOT = 4;
   localparam int SIFS = 2;
   localparam int LEN  = 40;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start_req = 1'b0;
   logic       ch_idle = 1'b1;
   logic       abort = 1'b0;
   logic [3:0] cw_exp = 4'd0;
   logic [3:0] aifsn = 4'd0;
   logic       backoff_done;
   logic       busy;
   logic [9:0] bo_remain;
   logic [1:0] bo_state;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] m_lfsr;
   logic        d_log [LEN+1];
   logic        b_log [LEN+1];
   logic [9:0]  r_log [LEN+1];
   logic [1:0]  s_log [LEN+1];
   int          bz_from, bz_to, abort_at, rst_at, restart_at;
   logic [9:0]  exp_draw;
   int          done_at, done_cnt;

   always #5 clk = ~clk;

   backoff_ctl #(
      .SLOT_CYCLES (SLOT),
      .SIFS_CYCLES (SIFS),
      .LFSR_SEED   (16'hACE1),
      .CW_EXP_MAX  (10)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start_req    (start_req),
      .cw_exp       (cw_exp),
      .aifsn        (aifsn),
      .ch_idle      (ch_idle),
      .abort        (abort),
      .backoff_done (backoff_done),
      .busy         (busy),
      .bo_remain    (bo_remain),
      .bo_state     (bo_state)
   );

   // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois right-shift form.
   always @(posedge clk) begin
      if (!rstn) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] mask_of(input logic [3:0] cw);
      int e;
      e = (cw > 4'd10) ? 10 : int'(cw);
      return 10'((1 << e) - 1);
   endfunction

   task automatic knobs(input int bf, input int bt, input int ab, input int rs, input int rr);
      bz_from = bf; bz_to = bt; abort_at = ab; rst_at = rs; restart_at = rr;
   endtask

   // Interval 0 carries start_req; interval c logs outputs seen after c clock edges.
   task automatic run(input string tag, input logic [3:0] cw, input logic [3:0] an, input int want);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (want >= 0 && int'(m_lfsr[9:0] & mask_of(cw)) != want && n < 500);
      if (want >= 0) chk({tag, "_draw_found"}, 32'(m_lfsr[9:0] & mask_of(cw)), want);
      exp_draw  = m_lfsr[9:0] & mask_of(cw);
      start_req = 1'b1; cw_exp = cw; aifsn = an; ch_idle = 1'b1;
      done_at   = -1; done_cnt = 0;
      for (int c = 1; c <= LEN; c++) begin
         @(negedge clk);
         d_log[c] = backoff_done; b_log[c] = busy; r_log[c] = bo_remain; s_log[c] = bo_state;
         if (backoff_done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         start_req = (c == restart_at);
         cw_exp    = (c == restart_at) ? 4'd4 : cw;
         aifsn     = (c == restart_at) ? 4'd15 : an;
         ch_idle   = !(c >= bz_from && c < bz_to);
         abort     = (c == abort_at);
         rstn      = (c != rst_at);
      end
      start_req = 1'b0; abort = 1'b0; ch_idle = 1'b1; rstn = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] seen;
      int bad, mx, bsum;

      repeat (3) @(negedge clk);
      chk("rst_done", backoff_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_remain", bo_remain, 0);
      chk("rst_state", bo_state, 0);

      // First draw after reset uses the seed: 0xACE1[9:0] = 0x0E1.
      rstn = 1'b1; start_req = 1'b1; cw_exp = 4'd10; aifsn = 4'd0;
      @(negedge clk);
      start_req = 1'b0;
      chk("seed_draw", bo_remain, 10'h0E1);
      chk("seed_state", bo_state, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_wait_busy", busy, 0);

      // 1: zero window, aifs_len 10
      knobs(0, 0, -1, -1, -1);
      run("t1", 4'd0, 4'd2, -1);
      chk("t1_remain", r_log[1], 0);
      chk("t1_done_at", done_at, 11);
      chk("t1_done_cnt", done_cnt, 1);
      bsum = 0;
      for (int c = 1; c <= LEN; c++) bsum += int'(b_log[c]);
      chk("t1_busy_cycles", bsum, 11);
      chk("t1_busy_first", b_log[1], 1);
      chk("t1_busy_after", b_log[12], 0);
      chk("t1_state_done", s_log[11], 3);

      // 2a: draw 3, aifs_len 6
      run("t2a", 4'd2, 4'd1, 3);
      chk("t2a_remain", r_log[1], 3);
      chk("t2a_state_wait", s_log[6], 1);
      chk("t2a_state_bo", s_log[7], 2);
      chk("t2a_after_slot1", r_log[11], 2);
      chk("t2a_done_at", done_at, 19);
      chk("t2a_done_cnt", done_cnt, 1);
      chk("t2a_remain_end", r_log[19], 0);

      // 2b: busy 5 cycles one cycle into slot 2
      knobs(12, 17, -1, -1, -1);
      run("t2b", 4'd2, 4'd1, 3);
      chk("t2b_frozen", r_log[13], 2);
      chk("t2b_state_wait", s_log[13], 1);
      chk("t2b_frozen_late", r_log[16], 2);
      chk("t2b_aifs_rerun", s_log[22], 1);
      chk("t2b_bo_resume", s_log[23], 2);
      chk("t2b_done_at", done_at, 31);
      chk("t2b_done_cnt", done_cnt, 1);

      // 3: draw distribution with clamping
      for (int pass = 0; pass < 2; pass++) begin
         seen = '0; bad = 0; mx = 0;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cw_exp = (pass == 0) ? 4'd4 : 4'd15;
            exp_draw = m_lfsr[9:0] & mask_of(cw_exp);
            start_req = 1'b1; aifsn = 4'd0;
            @(negedge clk);
            start_req = 1'b0;
            if (bo_remain !== exp_draw) bad++;
            if (int'(bo_remain) > mx) mx = int'(bo_remain);
            seen[bo_remain[3:0]] = 1'b1;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
         end
         if (pass == 0) begin
            chk("t3_cw4_draws", bad, 0);
            chk("t3_cw4_max_ok", mx <= 15, 1);
            chk("t3_cw4_all_seen", seen, 16'hFFFF);
         end else begin
            chk("t3_cw15_draws", bad, 0);
            chk("t3_cw15_max_ok", mx <= 1023, 1);
            chk("t3_cw15_wide", mx > 15, 1);
         end
      end

      // 4a: abort mid-BACKOFF with 5 slots left (aifsn 0 -> AIFS = SIFS)
      knobs(0, 0, 4, -1, -1);
      run("t4a", 4'd3, 4'd0, 5);
      chk("t4a_state_bo", s_log[3], 2);
      chk("t4a_remain", r_log[4], 5);
      chk("t4a_state_idle", s_log[5], 0);
      chk("t4a_busy", b_log[5], 0);
      chk("t4a_no_done", done_cnt, 0);

      // 4b: abort on the cycle that would enter DONE
      knobs(0, 0, 2, -1, -1);
      run("t4b", 4'd0, 4'd0, -1);
      chk("t4b_state", s_log[3], 0);
      chk("t4b_no_done", done_cnt, 0);

      // 4c: abort while already in DONE lets the pulse complete
      knobs(0, 0, 3, -1, -1);
      run("t4c", 4'd0, 4'd0, -1);
      chk("t4c_done_at", done_at, 3);
      chk("t4c_done_cnt", done_cnt, 1);
      chk("t4c_idle", s_log[4], 0);

      // 5: reset pulse during WAIT_AIFS, then a normal run
      knobs(0, 0, -1, 3, -1);
      run("t5a", 4'd4, 4'd2, 9);
      chk("t5a_pre_remain", r_log[3], 9);
      chk("t5a_pre_state", s_log[3], 1);
      chk("t5a_busy", b_log[4], 0);
      chk("t5a_done", d_log[4], 0);
      chk("t5a_remain", r_log[4], 0);
      chk("t5a_state", s_log[4], 0);
      chk("t5a_no_done", done_cnt, 0);
      knobs(0, 0, -1, -1, -1);
      run("t5b", 4'd2, 4'd1, -1);
      chk("t5b_remain", r_log[1], exp_draw);
      chk("t5b_done_at", done_at, 7 + SLOT * int'(exp_draw));
      chk("t5b_done_cnt", done_cnt, 1);

      // 6: start_req during WAIT_AIFS is ignored
      knobs(0, 0, -1, -1, 3);
      run("t6", 4'd2, 4'd1, 3);
      chk("t6_remain", r_log[4], 3);
      chk("t6_state", s_log[4], 1);
      chk("t6_done_at", done_at, 19);
      chk("t6_done_cnt", done_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
